// File: rtl/stack_op_sequencer.sv
// ============================================================================
// Module   : stack_op_sequencer
// Purpose  : Issues push/pop/tos strobes to the operand stack for one stack
//            instruction per start pulse, traps underflow/overflow up front.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stack_op_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] st_dout,
    output logic             st_push,
    output logic             st_pop,
    output logic             st_tos,
    output logic [WIDTH-1:0] st_din,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [DEPTH:0]   count
);

    localparam logic [2:0] c_op_pushi = 3'd0;
    localparam logic [2:0] c_op_pop   = 3'd1;
    localparam logic [2:0] c_op_add   = 3'd2;
    localparam logic [2:0] c_op_sub   = 3'd3;
    localparam logic [2:0] c_op_and   = 3'd4;
    localparam logic [2:0] c_op_not   = 3'd5;
    localparam logic [2:0] c_op_tos   = 3'd6;
    localparam logic [2:0] c_op_dup   = 3'd7;

    localparam logic [DEPTH:0] c_full = {1'b1, {DEPTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_B   = 3'd1,
        S_RD_A   = 3'd2,
        S_GET_A  = 3'd3,
        S_WRITE  = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_imm;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_err;
    logic [WIDTH-1:0] r_result;
    logic [DEPTH:0]   r_count;
    logic [DEPTH:0]   w_need;
    logic             w_trap;
    logic [WIDTH-1:0] w_push_val;

    // Operand requirement is judged on the incoming opcode, before latching.
    always_comb begin
        w_need = '0;
        case (opcode)
            c_op_add, c_op_sub, c_op_and: w_need = (DEPTH+1)'(2);
            c_op_pushi:                   w_need = '0;
            default:                      w_need = (DEPTH+1)'(1);
        endcase
    end

    assign w_trap = (r_count < w_need) ||
                    (((opcode == c_op_pushi) || (opcode == c_op_dup)) && (r_count == c_full));

    always_comb begin
        w_push_val = '0;
        case (r_op)
            c_op_pushi: w_push_val = r_imm;
            c_op_add:   w_push_val = r_a + r_b;
            c_op_sub:   w_push_val = r_a - r_b;
            c_op_and:   w_push_val = r_a & r_b;
            c_op_not:   w_push_val = ~r_b;
            c_op_dup:   w_push_val = r_b;
            default:    w_push_val = '0;
        endcase
    end

    always_comb begin
        w_next  = r_state;
        st_push = 1'b0;
        st_pop  = 1'b0;
        st_tos  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_trap)
                        w_next = S_FINISH;
                    else if (opcode == c_op_pushi)
                        w_next = S_WRITE;
                    else
                        w_next = S_RD_B;
                end
            end
            S_RD_B: begin
                if ((r_op == c_op_tos) || (r_op == c_op_dup))
                    st_tos = 1'b1;
                else
                    st_pop = 1'b1;
                w_next = S_RD_A;
            end
            S_RD_A: begin
                case (r_op)
                    c_op_add, c_op_sub, c_op_and: begin
                        st_pop = 1'b1;
                        w_next = S_GET_A;
                    end
                    c_op_not, c_op_dup: w_next = S_WRITE;
                    default:            w_next = S_FINISH;
                endcase
            end
            S_GET_A:  w_next = S_WRITE;
            S_WRITE: begin
                st_push = 1'b1;
                w_next  = S_FINISH;
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_imm    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_err    <= 1'b0;
            r_result <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_next;
            if (st_push)
                r_count <= r_count + (DEPTH+1)'(1);
            else if (st_pop)
                r_count <= r_count - (DEPTH+1)'(1);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op  <= opcode;
                        r_imm <= imm;
                        r_err <= w_trap;
                    end
                end
                S_RD_A: begin
                    r_b <= st_dout;
                    if ((r_op == c_op_pop) || (r_op == c_op_tos))
                        r_result <= st_dout;
                end
                S_GET_A: r_a      <= st_dout;
                S_WRITE: r_result <= w_push_val;
                default: ;
            endcase
        end
    end

    assign st_din = st_push ? w_push_val : '0;
    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_FINISH);
    assign err    = (r_state == S_FINISH) && r_err;
    assign result = r_result;
    assign count  = r_count;

endmodule

`default_nettype wire

// File: tb/tb_stack_op_sequencer.sv
// ============================================================================
// Module   : tb_stack_op_sequencer
// Purpose  : Directed scoreboard bench for stack_op_sequencer with a stack model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stack_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] opcode;
    logic [7:0] imm;
    logic [7:0] st_dout;
    logic       st_push, st_pop, st_tos;
    logic [7:0] st_din;
    logic       busy, done, err;
    logic [7:0] result;
    logic [7:0] count;

    stack_op_sequencer #(.WIDTH(8), .DEPTH(7)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .imm(imm),
        .st_dout(st_dout), .st_push(st_push), .st_pop(st_pop), .st_tos(st_tos),
        .st_din(st_din), .busy(busy), .done(done), .err(err),
        .result(result), .count(count)
    );

    always #5 clk = ~clk;

    // Behavioural operand stack with registered read data.
    logic [7:0] mem [0:127];
    logic [7:0] sp;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp      <= '0;
            st_dout <= '0;
        end else if (st_push) begin
            mem[sp[6:0]] <= st_din;
            sp           <= sp + 8'd1;
        end else if (st_pop) begin
            st_dout <= mem[7'(sp - 8'd1)];
            sp      <= sp - 8'd1;
        end else if (st_tos) begin
            st_dout <= mem[7'(sp - 8'd1)];
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        e_err;
        logic [7:0]  e_res;
        logic [7:0]  e_cnt;
        logic [15:0] e_seq;
        logic [7:0]  e_din;
        int          e_cyc;
    } exp_t;
    exp_t q[$];

    // Monitor: strobe trace per instruction, compared on each done pulse.
    logic [15:0] seq;
    logic [7:0]  din_seen;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            seq      = '0;
            din_seen = '0;
        end else begin
            if ({st_push, st_pop, st_tos} != 3'b000) begin
                seq = {seq[11:0], 1'b0, st_push, st_pop, st_tos};
                if (st_push) din_seen = st_din;
            end
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("err",     32'(err),      32'(e.e_err));
                    check("result",  32'(result),   32'(e.e_res));
                    check("count",   32'(count),    32'(e.e_cnt));
                    check("strobes", 32'(seq),      32'(e.e_seq));
                    check("st_din",  32'(din_seen), 32'(e.e_din));
                    check("latency", 32'(cyc),      32'(e.e_cyc));
                end
                seq      = '0;
                din_seen = '0;
            end
        end
    end

    // Issue at a negedge in IDLE; returns at the negedge after done (IDLE again).
    task automatic issue(input logic [2:0] op, input logic [7:0] im, input logic e_err,
                         input logic [7:0] e_res, input logic [7:0] e_cnt,
                         input logic [15:0] e_seq, input logic [7:0] e_din,
                         input int lat, input int inj);
        exp_t e;
        bit   seen;
        e.e_err = e_err; e.e_res = e_res; e.e_cnt = e_cnt;
        e.e_seq = e_seq; e.e_din = e_din; e.e_cyc = cyc + lat;
        q.push_back(e);
        start = 1'b1; opcode = op; imm = im;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (k == inj) begin
                start = 1'b1; opcode = 3'd0; imm = 8'h55;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic check_reset();
        check("rst_push",   32'(st_push), 32'd0);
        check("rst_pop",    32'(st_pop),  32'd0);
        check("rst_tos",    32'(st_tos),  32'd0);
        check("rst_din",    32'(st_din),  32'd0);
        check("rst_busy",   32'(busy),    32'd0);
        check("rst_done",   32'(done),    32'd0);
        check("rst_err",    32'(err),     32'd0);
        check("rst_result", 32'(result),  32'd0);
        check("rst_count",  32'(count),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; opcode = '0; imm = '0;
        repeat (3) @(negedge clk);
        check_reset();
        rst = 1'b1;
        @(negedge clk);

        // opcode, imm, err, result, count, strobes, st_din, latency, inject
        issue(3'd0, 8'h05, 1'b0, 8'h05, 8'd1, 16'h0004, 8'h05, 2, -1);
        issue(3'd0, 8'h03, 1'b0, 8'h03, 8'd2, 16'h0004, 8'h03, 2, -1);
        issue(3'd3, 8'h00, 1'b0, 8'h02, 8'd1, 16'h0224, 8'h02, 5, -1);
        issue(3'd1, 8'h00, 1'b0, 8'h02, 8'd0, 16'h0002, 8'h00, 3, -1);

        issue(3'd0, 8'hF0, 1'b0, 8'hF0, 8'd1, 16'h0004, 8'hF0, 2, -1);
        issue(3'd0, 8'h20, 1'b0, 8'h20, 8'd2, 16'h0004, 8'h20, 2, -1);
        issue(3'd2, 8'h00, 1'b0, 8'h10, 8'd1, 16'h0224, 8'h10, 5, -1);
        issue(3'd5, 8'h00, 1'b0, 8'hEF, 8'd1, 16'h0024, 8'hEF, 4, -1);
        issue(3'd1, 8'h00, 1'b0, 8'hEF, 8'd0, 16'h0002, 8'h00, 3, -1);

        // Underflow traps
        issue(3'd1, 8'h00, 1'b1, 8'hEF, 8'd0, 16'h0000, 8'h00, 1, -1);
        issue(3'd0, 8'h11, 1'b0, 8'h11, 8'd1, 16'h0004, 8'h11, 2, -1);
        issue(3'd2, 8'h00, 1'b1, 8'h11, 8'd1, 16'h0000, 8'h00, 1, -1);

        // Fill to capacity, then overflow traps and TOS on a full stack
        for (int i = 0; i < 127; i++)
            issue(3'd0, 8'(i * 3), 1'b0, 8'(i * 3), 8'(i + 2), 16'h0004, 8'(i * 3), 2, -1);
        issue(3'd0, 8'hAA, 1'b1, 8'h7A, 8'd128, 16'h0000, 8'h00, 1, -1);
        issue(3'd7, 8'h00, 1'b1, 8'h7A, 8'd128, 16'h0000, 8'h00, 1, -1);
        issue(3'd6, 8'h00, 1'b0, 8'h7A, 8'd128, 16'h0001, 8'h00, 3, -1);

        // Fresh reset, DUP with an ignored start while busy
        rst = 1'b0;
        @(negedge clk);
        check_reset();
        rst = 1'b1;
        @(negedge clk);
        issue(3'd0, 8'h7E, 1'b0, 8'h7E, 8'd1, 16'h0004, 8'h7E, 2, -1);
        issue(3'd7, 8'h00, 1'b0, 8'h7E, 8'd2, 16'h0014, 8'h7E, 4, 1);
        repeat (4) @(negedge clk);
        check("dup_count_settled", 32'(count), 32'd2);

        // Reset in GET_A of an ADD abandons it
        start = 1'b1; opcode = 3'd2; imm = 8'h00;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        issue(3'd0, 8'h01, 1'b0, 8'h01, 8'd1, 16'h0004, 8'h01, 2, -1);
        repeat (5) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stack_op_sequencer.md
Name: stack_op_sequencer

Overview:
- Micro-sequencer that sits directly upstream of the CPU operand stack and is the only block that drives its push/pop/tos strobes and write data.
- Takes one stack instruction per start pulse and issues the required strobe sequence.
- Captures the registered read data the stack returns, evaluates the ALU function and pushes the result.
- Tracks stack occupancy, so underflow and overflow are trapped before any strobe is issued.

Parameters:
- WIDTH, 8, data word width; must equal the stack's WIDTH.
- DEPTH, 7, stack address width; capacity is 2^DEPTH entries; must equal the stack's DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle instruction request; sampled only in IDLE.
- opcode  in  3  0 PUSHI, 1 POP, 2 ADD, 3 SUB, 4 AND, 5 NOT, 6 TOS, 7 DUP.
- imm  in  WIDTH  immediate for PUSHI; sampled with start.
- st_dout  in  WIDTH  stack read data; registered, valid the cycle after st_pop or st_tos.
- st_push  out  1  stack push strobe.
- st_pop  out  1  stack pop strobe.
- st_tos  out  1  stack top-of-stack read strobe.
- st_din  out  WIDTH  stack write data; the push value while st_push=1, otherwise 0.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done; high on a trapped underflow or overflow.
- result  out  WIDTH  last completed value; held until the next successful completion.
- count  out  DEPTH+1  current occupancy, 0..2^DEPTH.

Behaviour:
- Reset: state=IDLE; all strobes, busy, done and err = 0; result=0, st_din=0, count=0.
- Reset may assert in any state; the sequencer returns to IDLE and abandons the instruction.
- At integration, rst is also inverted to drive the stack's active-high reset, so count and the stack pointer clear together.
- Strobes: at most one of st_push/st_pop/st_tos is high in any cycle. Each is exactly one cycle and is driven only in the states listed below.
- States: IDLE, RD_B, RD_A, GET_A, WRITE, FINISH.
- IDLE, start=1:
  - Latch opcode and imm.
  - Underflow check: required operands are 2 for ADD/SUB/AND, 1 for POP/NOT/TOS/DUP, 0 for PUSHI. If count is below the requirement, trap.
  - Overflow check: PUSHI or DUP with count = 2^DEPTH traps.
  - Trap: go to FINISH with err set and no strobes. count and result are unchanged.
  - No trap: PUSHI goes to WRITE; all other opcodes go to RD_B.
- start outside IDLE is ignored; it is not queued.
- RD_B: assert st_tos for TOS/DUP, st_pop otherwise; next state RD_A.
- RD_A:
  - Capture b <= st_dout.
  - ADD/SUB/AND: assert st_pop; next GET_A.
  - NOT/DUP: next WRITE.
  - POP/TOS: next FINISH, with result <= st_dout.
- GET_A: capture a <= st_dout; next WRITE.
- WRITE: assert st_push with st_din equal to:
  - PUSHI: imm
  - ADD: a+b
  - SUB: a-b
  - AND: a&b
  - NOT: ~b
  - DUP: b
  - result takes the same value at this edge; next FINISH.
- Arithmetic: modulo 2^WIDTH. No carry or overflow flag. b is always the former top of stack.
- FINISH: done=1 for one cycle, err as latched; next IDLE. busy drops in the cycle after done.
- count: +1 on each cycle with st_push, -1 on each cycle with st_pop, unchanged on st_tos.
- Latency, from the start edge to the cycle done is high:
  - trap: 1
  - PUSHI: 2
  - POP/TOS: 3
  - NOT/DUP: 4
  - ADD/SUB/AND: 5
- Back-to-back: a start in the cycle after done is accepted.

Test Plan:
- Reset, then PUSHI 0x05 and PUSHI 0x03, then SUB -> strobe order pop, pop, push with st_din=0x02; done 5 cycles after start; result=0x02; count goes 2 -> 1.
- Stack holds [0xF0, 0x20], then ADD -> st_din=0x10 (wrap); then NOT -> st_din=0xEF; then POP -> result=0xEF, count=0.
- Empty stack, POP -> done=err=1 one cycle after start; no strobes; result and count unchanged. ADD with count=1 -> same trap response.
- Fill to 128 with PUSHI, then PUSHI 0xAA -> err=1, no st_push. Then DUP -> err=1. Then TOS -> only st_tos strobed, result equals the last pushed value, count stays 128.
- DUP on [0x7E] -> st_tos then st_push with st_din=0x7E, count=2. start pulsed while busy is ignored: exactly one done.
- Assert rst during GET_A of an ADD -> all outputs at reset values immediately; no push follows. After release, PUSHI 0x01 completes normally with count=1.
